// File: rtl/mvu_seq_accumulator.sv
// mvu_seq_accumulator: lane-wise signed accumulation over ilast-delimited sequences,
// one result word per sequence through a 2-entry FIFO with registered head.
module mvu_seq_accumulator #(
  parameter int PE = 4,
  parameter int IW = 16,
  parameter int AW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PE*IW-1:0] idat,
  input  logic             ilast,
  input  logic             ifin,
  input  logic             ivld,
  output logic             irdy,
  output logic [PE*AW-1:0] odat,
  output logic             olast,
  output logic             ovld,
  input  logic             ordy
);
  if (PE < 1 || IW < 1 || AW < IW) begin : g_bad
    $error("mvu_seq_accumulator: illegal parameters PE=%0d IW=%0d AW=%0d", PE, IW, AW);
  end
  logic [PE*AW-1:0] acc, sum, tail_dat;
  logic             tail_last, first, take, push, pop, to_head;
  logic [1:0]       cnt;
  assign irdy    = cnt != 2'd2;
  assign ovld    = cnt != 2'd0;
  assign take    = ivld && irdy;
  assign push    = take && ilast;
  assign pop     = ovld && ordy;
  // new entry lands in the head when the queue is empty or its only entry leaves now
  assign to_head = cnt == 2'd0 || (cnt == 2'd1 && pop);
  for (genvar i = 0; i < PE; i++) begin : g_lane
    assign sum[i*AW +: AW] = (first ? '0 : acc[i*AW +: AW]) + AW'($signed(idat[i*IW +: IW]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first <= 1'b1;
      cnt   <= 2'd0;
    end else begin
      if (take) first <= ilast;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (take) acc <= sum;
    if (push && to_head) {olast, odat} <= {ifin, sum};
    else if (pop) {olast, odat} <= {tail_last, tail_dat};
    if (push && !to_head) {tail_last, tail_dat} <= {ifin, sum};
  end
endmodule

// File: tb/tb_mvu_seq_accumulator.sv
// tb_mvu_seq_accumulator: randomized and directed checks against a queue-based reference model.
module tb_mvu_seq_accumulator;
  localparam int PE = 4, IW = 16, AW = 32;
  typedef logic [PE*AW:0] entry_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [PE*IW-1:0] idat = '0;
  logic ilast = 1'b0, ifin = 1'b0, ivld = 1'b0, ordy = 1'b0;
  logic irdy, olast, ovld;
  logic [PE*AW-1:0] odat;
  logic [15:0] w_idat = '0;
  logic w_ilast = 1'b0, w_ifin = 1'b0, w_ivld = 1'b0, w_ordy = 1'b0;
  logic w_irdy, w_olast, w_ovld;
  logic [15:0] w_odat;
  int total = 0, bad = 0;
  entry_t exp_q[$];
  longint macc[PE];
  bit mfirst = 1'b1;

  always #5 clk = ~clk;

  mvu_seq_accumulator #(.PE(PE), .IW(IW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .idat(idat), .ilast(ilast), .ifin(ifin), .ivld(ivld),
    .irdy(irdy), .odat(odat), .olast(olast), .ovld(ovld), .ordy(ordy));

  mvu_seq_accumulator #(.PE(2), .IW(8), .AW(8)) wdut (
    .clk(clk), .rst_n(rst_n), .idat(w_idat), .ilast(w_ilast), .ifin(w_ifin), .ivld(w_ivld),
    .irdy(w_irdy), .odat(w_odat), .olast(w_olast), .ovld(w_ovld), .ordy(w_ordy));

  // Drives one cycle and advances the reference model: a sequence result is the plain
  // integer sum of its beats, truncated to AW bits, queued in arrival order.
  task automatic step(input logic v, input logic [PE*IW-1:0] d, input logic l, input logic f, input logic r);
    bit acc_ok, pop_ok;
    entry_t e;
    ivld = v; idat = d; ilast = l; ifin = f; ordy = r;
    acc_ok = v && exp_q.size() < 2;
    pop_ok = r && exp_q.size() != 0;
    @(posedge clk);
    if (pop_ok) void'(exp_q.pop_front());
    if (acc_ok) begin
      for (int i = 0; i < PE; i++) macc[i] = (mfirst ? 64'sd0 : macc[i]) + longint'($signed(d[i*IW +: IW]));
      mfirst = l;
      if (l) begin
        for (int i = 0; i < PE; i++) e[i*AW +: AW] = macc[i][AW-1:0];
        e[PE*AW] = f;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ivld = 1'b0; ordy = 1'b0; w_ivld = 1'b0; w_ordy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mfirst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ovld !== 1'b0) begin bad++; $display("FAIL reset_ovld got=%b exp=0", ovld); end
    total++; if (irdy !== 1'b1) begin bad++; $display("FAIL reset_irdy got=%b exp=1", irdy); end
    total++; if (w_ovld !== 1'b0) begin bad++; $display("FAIL reset_w_ovld got=%b exp=0", w_ovld); end
  endtask

  task automatic test_sum3();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, {PE{16'(k)}}, k == 3, 1'b0, 1'b1);
      if (k == 2) begin
        total++; if (ovld !== 1'b0) begin bad++; $display("FAIL sum3_early_ovld got=%b exp=0", ovld); end
      end
    end
    total++; if (ovld !== 1'b1) begin bad++; $display("FAIL sum3_ovld got=%b exp=1", ovld); end
    total++; if (odat !== {PE{32'd6}}) begin bad++; $display("FAIL sum3_odat got=%h exp=%h", odat, {PE{32'd6}}); end
    total++; if (olast !== 1'b0) begin bad++; $display("FAIL sum3_olast got=%b exp=0", olast); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (ovld !== 1'b0) begin bad++; $display("FAIL sum3_drain got=%b exp=0", ovld); end
  endtask

  task automatic test_sext();
    logic [PE*IW-1:0] d;
    d = {16'd0, 16'd0, 16'h7FFF, 16'hFFFF};
    step(1'b1, d, 1'b0, 1'b0, 1'b1);
    step(1'b1, d, 1'b1, 1'b0, 1'b1);
    total++; if (odat[31:0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sext_lane0 got=%h exp=fffffffe", odat[31:0]); end
    total++; if (odat[63:32] !== 32'd65534) begin bad++; $display("FAIL sext_lane1 got=%0d exp=65534", odat[63:32]); end
    total++; if (odat[127:64] !== 64'd0) begin bad++; $display("FAIL sext_lane23 got=%h exp=0", odat[127:64]); end
    step(1'b1, {48'd0, 16'hFFFB}, 1'b1, 1'b0, 1'b1);
    total++; if (odat[31:0] !== 32'hFFFF_FFFB) begin bad++; $display("FAIL sext_single got=%h exp=fffffffb", odat[31:0]); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    step(1'b1, {PE{16'd10}}, 1'b1, 1'b0, 1'b0);
    total++; if (irdy !== 1'b1) begin bad++; $display("FAIL stall_irdy1 got=%b exp=1", irdy); end
    step(1'b1, {PE{16'd20}}, 1'b1, 1'b0, 1'b0);
    total++; if (irdy !== 1'b0) begin bad++; $display("FAIL stall_irdy_full got=%b exp=0", irdy); end
    step(1'b1, {PE{16'd30}}, 1'b1, 1'b0, 1'b0);
    total++; if (irdy !== 1'b0) begin bad++; $display("FAIL stall_irdy_held got=%b exp=0", irdy); end
    total++; if (odat !== {PE{32'd10}}) begin bad++; $display("FAIL stall_head got=%h exp=%h", odat, {PE{32'd10}}); end
    step(1'b1, {PE{16'd30}}, 1'b1, 1'b0, 1'b1);
    total++; if (irdy !== 1'b1) begin bad++; $display("FAIL stall_irdy_rise got=%b exp=1", irdy); end
    total++; if (odat !== {PE{32'd20}}) begin bad++; $display("FAIL stall_second got=%h exp=%h", odat, {PE{32'd20}}); end
    step(1'b1, {PE{16'd30}}, 1'b1, 1'b0, 1'b1);
    total++; if (odat !== {PE{32'd30}}) begin bad++; $display("FAIL stall_third got=%h exp=%h", odat, {PE{32'd30}}); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (ovld !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", ovld); end
  endtask

  task automatic test_fin();
    for (int s = 0; s < 4; s++) begin
      step(1'b1, {PE{16'(s)}}, 1'b0, 1'b1, 1'b1);
      step(1'b1, {PE{16'd1}}, 1'b1, s == 3, 1'b1);
      total++; if (olast !== (s == 3)) begin bad++; $display("FAIL fin_olast%0d got=%b exp=%b", s, olast, s == 3); end
      total++; if (odat !== {PE{32'(s + 1)}}) begin bad++; $display("FAIL fin_odat%0d got=%h exp=%h", s, odat, {PE{32'(s + 1)}}); end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [PE*IW-1:0] d;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < PE; i++) d[i*IW +: IW] = IW'($urandom);
      step(1'b1, d, 1'b1, 1'(k & 1), 1'b1);
      total++; if (irdy !== 1'b1) begin bad++; $display("FAIL b2b_irdy%0d got=%b exp=1", k, irdy); end
      total++; if ({olast, odat} !== exp_q[0]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, {olast, odat}, exp_q[0]); end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    w_ordy = 1'b1; w_ivld = 1'b1; w_ilast = 1'b0; w_idat = {8'h80, 8'd100};
    @(posedge clk); @(negedge clk);
    w_ilast = 1'b1; w_idat = {8'hFF, 8'd100};
    @(posedge clk); @(negedge clk);
    w_ivld = 1'b0; w_ilast = 1'b0;
    total++; if (w_ovld !== 1'b1) begin bad++; $display("FAIL wrap_ovld got=%b exp=1", w_ovld); end
    total++; if (w_odat[7:0] !== 8'hC8) begin bad++; $display("FAIL wrap_lane0 got=%h exp=c8", w_odat[7:0]); end
    total++; if (w_odat[15:8] !== 8'h7F) begin bad++; $display("FAIL wrap_lane1 got=%h exp=7f", w_odat[15:8]); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_midreset();
    step(1'b1, {PE{16'd1}}, 1'b1, 1'b0, 1'b0);
    step(1'b1, {PE{16'd9}}, 1'b0, 1'b0, 1'b0);
    step(1'b1, {PE{16'd4}}, 1'b1, 1'b0, 1'b0);
    total++; if (irdy !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", irdy); end
    do_reset();
    total++; if (ovld !== 1'b0) begin bad++; $display("FAIL mid_ovld got=%b exp=0", ovld); end
    total++; if (irdy !== 1'b1) begin bad++; $display("FAIL mid_irdy got=%b exp=1", irdy); end
    step(1'b1, {PE{16'd50}}, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, {PE{16'd7}}, 1'b1, 1'b0, 1'b1);
    total++; if (odat !== {PE{32'd7}}) begin bad++; $display("FAIL mid_fresh got=%h exp=%h", odat, {PE{32'd7}}); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int beats = 0, cyc = 0;
    logic [PE*IW-1:0] d;
    logic v, l, f, r, plast;
    logic [PE*AW-1:0] pdat;
    bit pstall = 1'b0;
    while (beats < 10000 && cyc < 60000) begin
      total++; if (irdy !== (exp_q.size() < 2)) begin bad++; $display("FAIL rand_irdy c=%0d got=%b exp=%b", cyc, irdy, exp_q.size() < 2); end
      total++; if (ovld !== (exp_q.size() != 0)) begin bad++; $display("FAIL rand_ovld c=%0d got=%b exp=%b", cyc, ovld, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        total++; if ({olast, odat} !== exp_q[0]) begin bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", cyc, {olast, odat}, exp_q[0]); end
      end
      if (pstall) begin
        total++; if ({olast, odat} !== {plast, pdat}) begin bad++; $display("FAIL rand_stable c=%0d got=%h exp=%h", cyc, {olast, odat}, {plast, pdat}); end
      end
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      l = $urandom_range(0, 3) == 0;
      f = 1'($urandom_range(0, 1));
      for (int i = 0; i < PE; i++) d[i*IW +: IW] = IW'($urandom);
      if (v && exp_q.size() < 2) beats++;
      pstall = ovld && !r; pdat = odat; plast = olast;
      step(v, d, l, f, r);
      cyc++;
    end
    total++; if (beats < 10000) begin bad++; $display("FAIL rand_budget beats=%0d exp=10000", beats); end
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (ovld !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got=%b exp=0 left=%0d", ovld, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sum3();
    test_sext();
    test_stall();
    test_fin();
    test_back_to_back();
    test_wrap();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
